// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scan-code receiver:
//   - prefix byte constants (extended E0, break F0)
//   - frame state encoding for the bit-level receiver
//   - packed event layout pushed into the event FIFO
//   - odd-parity helper
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  // Event word: {ext, brk, code[7:0]}
  localparam int PS2_EVT_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ---------------------------------------------------------------------------
// ps2_event_fifo
// Parametrised show-ahead FIFO. The head word is visible on rd_data whenever
// the FIFO is non-empty and reads as zero when empty.
//
// Parameters:
//   DEPTH  entries (power of 2, >= 2)
//   W      word width
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request and word
//   pop             remove head (ignored while empty)
//   rd_data         head word (zero when empty)
//   level           registered occupancy, 0..DEPTH
//   full, empty     occupancy flags
//   overflow        one-cycle pulse: push dropped because FIFO was full
// ---------------------------------------------------------------------------
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));

  // A push into a full FIFO still succeeds when the head leaves in the same
  // cycle, so the slot being freed is reused and the level holds.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = push && !do_push;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the read port is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// ---------------------------------------------------------------------------
// ps2_scan_receiver
// PS/2 keyboard receiver: synchronises and glitch-filters the raw PS/2 clock,
// assembles 11-bit frames (start, 8 data LSB first, odd parity, stop), guards
// each frame with a watchdog, decodes E0/F0 prefixes into tagged key events
// and queues them in a show-ahead FIFO with a valid/ready output.
//
// Handshake: evt_valid is high while the FIFO head holds an event; the head
// (evt_code/evt_ext/evt_break) is stable until the cycle evt_valid & evt_ready
// is seen at a clk edge, at which point it is removed. Outputs read 0 while
// evt_valid is low.
//
// Parameters: FILTER_LEN, TIMEOUT_CYCLES, FIFO_DEPTH, FIFO_AW (derived).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ps2_clk, ps2_data          raw asynchronous PS/2 lines
//   evt_valid/evt_ready        event handshake
//   evt_code/evt_ext/evt_break head event fields
//   fifo_level                 queued event count
//   overflow                   pulse: event dropped, FIFO full
//   parity_err                 pulse: parity mismatch
//   frame_err                  pulse: bad stop bit or watchdog timeout
//
// Optional build macro PS2_REPEAT_FILTER_EN: suppresses typematic repeats of
// held keys using a 256-entry held-key bitmap indexed {ext, code[6:0]}.
// ---------------------------------------------------------------------------
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_AW        = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_break,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               parity_err,
  output logic               frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------- synchronisers (lines idle high) ----------------
  logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  // ---------------- clock filter + falling-edge strobe ----------------
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           strobe_q, strobe_d;

  // fcnt counts consecutive samples that disagree with the filtered level;
  // any agreeing sample restarts the count.
  always_comb begin
    filt_d   = filt_q;
    fcnt_d   = '0;
    strobe_d = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d   = clk_sync_q;
        strobe_d = filt_q;  // only the 1->0 change strobes
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      strobe_q <= strobe_d;
    end
  end

  // ---------------- frame FSM, watchdog and prefix decoder ----------------
  frame_state_e   state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           ext_q, ext_d;
  logic           brk_q, brk_d;
  logic           push_q, push_d;
  ps2_evt_t       push_evt_q, push_evt_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
`ifdef PS2_REPEAT_FILTER_EN
  logic [255:0]   held_q, held_d;
  logic [7:0]     held_idx;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    wd_d       = wd_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    push_d     = 1'b0;
    push_evt_d = push_evt_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    held_d     = held_q;
    held_idx   = {ext_q, shift_q[6:0]};
`endif

    if (state_q == IDLE) begin
      wd_d = '0;
      // A strobe with data high cannot be a start bit; ignore it.
      if (strobe_q && !dat_sync_q) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
    end else if (strobe_q) begin
      wd_d = '0;
      unique case (state_q)
        DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_sync_q) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (shift_q == PS2_EXT_PREFIX) begin
            ext_d = 1'b1;
          end else if (shift_q == PS2_BRK_PREFIX) begin
            brk_d = 1'b1;
          end else begin
            push_d          = 1'b1;
            push_evt_d.ext  = ext_q;
            push_evt_d.brk  = brk_q;
            push_evt_d.code = shift_q;
            ext_d           = 1'b0;
            brk_d           = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            // Codes with bit 7 set are outside the bitmap and always pass.
            if (!shift_q[7]) begin
              if (brk_q)                  held_d[held_idx] = 1'b0;
              else if (held_q[held_idx])  push_d = 1'b0;
              else                        held_d[held_idx] = 1'b1;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
      // No falling edge for TIMEOUT_CYCLES clocks: abandon the frame.
      state_d = IDLE;
      wd_d    = '0;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else begin
      wd_d = wd_q + WDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      push_q     <= 1'b0;
      push_evt_q <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      push_q     <= push_d;
      push_evt_q <= push_evt_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst) held_q <= '0;
    else     held_q <= held_d;
  end
`endif

  // ---------------- event queue ----------------
  ps2_evt_t head;
  logic     fifo_empty;
  logic     fifo_full_unused;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PS2_EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_evt_q),
    .pop       (evt_ready),
    .rd_data   (head),
    .level     (fifo_level),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  assign evt_valid  = !fifo_empty;
  assign evt_code   = head.code;
  assign evt_ext    = head.ext;
  assign evt_break  = head.brk;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
Parametrised successor to the team's PS/2 keyboard receiver. It filters the raw PS/2 clock and assembles 11-bit frames, checking start, odd parity and stop bits, with a watchdog timeout. It decodes the E0 (extended) and F0 (break) prefixes into tagged key events. Events are queued in a FIFO with a valid/ready interface toward the game-control logic.

Parameters:
FILTER_LEN, 4, consecutive equal synchronised samples needed before the filtered ps2_clk changes level (>=1)
TIMEOUT_CYCLES, 50000, clk cycles allowed between falling edges inside a frame before the frame is abandoned
FIFO_DEPTH, 8, event queue entries (power of 2, >=2)
FIFO_AW, $clog2(FIFO_DEPTH), derived pointer width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts the head this cycle
evt_code  out  8  scan code of head event
evt_ext  out  1  head event was E0-prefixed
evt_break  out  1  head event is a release (F0-prefixed)
fifo_level  out  FIFO_AW+1  number of queued events
overflow  out  1  one-cycle pulse: event dropped, FIFO full
parity_err  out  1  one-cycle pulse: parity mismatch
frame_err  out  1  one-cycle pulse: bad stop bit or timeout

Behaviour:
- Reset (rst=1 at a clk edge) clears all state: frame FSM to IDLE, prefix flags, FIFO pointers, filter. All outputs read 0. Reset mid-frame discards the partial frame.
- ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Filtered clock starts at 1. It changes only after FILTER_LEN consecutive synchronised samples differ from it.
- A 1->0 transition of the filtered clock produces a one-cycle strobe. ps2_data is sampled on the strobe.
- Frame FSM:
  - IDLE: strobe with data=0 -> DATA; with data=1 -> stay in IDLE (spurious edge ignored).
  - DATA: 8 strobes, bits captured LSB first -> PARITY.
  - PARITY: captured on strobe -> STOP.
  - STOP: on strobe -> IDLE. A byte is accepted only if the stop bit is 1 and XOR(data, parity)=1.
- Frame errors:
  - Stop bit 0 -> frame_err pulse, byte discarded, prefix flags cleared.
  - Parity mismatch (stop ok) -> parity_err pulse, byte discarded, prefix flags cleared.
- Watchdog: in any non-IDLE state, a counter runs and resets on each strobe. When it reaches TIMEOUT_CYCLES: frame_err pulse, FSM -> IDLE, prefix flags cleared.
- Decoder, for each accepted byte:
  - E0: set ext flag, no event.
  - F0: set brk flag, no event.
  - Any other byte: push {ext, brk, byte}, then clear both flags.
- Push happens in the cycle after the STOP strobe. evt_valid is high the following cycle, so latency from the stop strobe is 2 clks.
- FIFO is show-ahead: evt_code/evt_ext/evt_break present the head whenever evt_valid=1, and are forced to 0 when evt_valid=0.
- Pop when evt_valid & evt_ready.
- Push while full and no pop: event dropped, overflow pulse, contents unchanged. Push and pop together while full both succeed, level unchanged.
- Pop while empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- fifo_level is registered and exact.

Optional Feature:
PS2_REPEAT_FILTER_EN
- Defined: a 256-bit held-key bitmap indexed {ext, code[6:0]} is kept; codes >= 0x80 bypass it.
  - A make event whose bit is already set (typematic repeat) is not pushed.
  - A make event whose bit is clear sets it and is pushed.
  - A break event clears the bit and is pushed.
  - rst clears the bitmap.
- Undefined: every make is pushed, including repeats; no bitmap logic exists.

Decomposition:
- Package ps2_pkg holds:
  - Constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0
  - Frame state encoding (IDLE, DATA, PARITY, STOP)
  - Event width constant PS2_EVT_W=10
- One sub-module: ps2_event_fifo, a parametrised show-ahead FIFO with level, full/empty and overflow-pulse outputs.

Test Plan:
- Frame 0x1C (parity 0, stop 1), evt_ready=1 -> one event {code=1C, ext=0, break=0}; evt_valid high 2 clks after the stop strobe.
- Frames E0,F0,75 -> single event {75, ext=1, break=1}; next frame 75 -> {75, 0, 0}.
- Frame 0x1C with parity 1 -> parity_err pulse, no event. Then E0 with stop=0 followed by 74 -> frame_err pulse, then event {74, ext=0}.
- Hold ps2_clk high after 5 bits for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next clean frame 0x29 decodes correctly.
- evt_ready=0, send FIFO_DEPTH+1 frames -> fifo_level=8, one overflow pulse; drain yields the first 8 codes in order. Push+pop same cycle at full keeps level 8.
- With PS2_REPEAT_FILTER_EN: 1C,1C,1C,F0,1C,1C -> events {1C make}, {1C break}, {1C make} only.
